cla_multiword_sequencer: RTL and testbench
==========================================

# cla_multiword_sequencer

Multi-precision add controller that sequences a single 16-bit carry-lookahead adder over `WORDS` 16-bit slices, least-significant first. It registers the inter-slice carry so one shared 16-bit adder can produce `16*WORDS`-bit sums. It sits between a requester issuing wide add operations and the 16-bit adder datapath, which it instantiates internally with ports `s`, `cout`, `a`, `b` and `cin`.

## Interface
- `WORDS`, default 4: number of 16-bit slices. Legal range 1..8. Operand width `W = 16*WORDS`.
- `clk  input  1`: single clock, rising-edge active.
- `rst_n  input  1`: reset, asynchronous assert, active-low. Clears all state.
- `start  input  1`: request a new operation. Sampled only in IDLE.
- `a_in  input  W`: operand A. Latched on the accepted `start`.
- `b_in  input  W`: operand B. Latched on the accepted `start`.
- `cin  input  1`: carry into slice 0. Latched on the accepted `start`.
- `busy  output  1`: high in RUN and DONE.
- `done  output  1`: one-cycle pulse, high only in DONE.
- `sum  output  W`: result register. Holds its value until the next accepted `start`.
- `cout  output  1`: carry out of the top slice. Valid when `done`=1, then held.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE after the slice with `idx`=`WORDS`-1 is processed.
  - DONE → IDLE unconditionally.
- On an accepted `start`:
  - latch A, B, `cin` into the carry register;
  - `idx` ← 0;
  - `sum` ← 0, `cout` ← 0.
- Each RUN cycle:
  - adder inputs are `a = A[16*idx +: 16]`, `b = B[16*idx +: 16]`, `cin` = carry register;
  - on the edge, `sum[16*idx +: 16]` ← `s`, carry ← adder `cout`, `idx` ← `idx`+1;
  - on the last slice, output `cout` ← adder `cout`.
- Arithmetic is modulo 2^W. `cout` is the true carry out of bit W-1. `idx` is 3 bits wide.
- `start` is ignored in RUN and DONE. No queuing.
- `a_in`, `b_in` and `cin` may change freely after the accepting edge. Only the latched copies are used.
- Reset, including mid-operation:
  - state ← IDLE;
  - `busy`, `done`, `cout` ← 0;
  - `sum` ← 0;
  - the carry register and `idx` ← 0;
  - no `done` pulse is produced for the aborted operation.
- `WORDS`=1: a single RUN cycle.

## Timing
- Edge T samples `start`=1 in IDLE. `busy` is high from after edge T.
- Slice k is written at edge T+1+k, for k = 0..WORDS-1.
- `done`=1 for exactly one cycle, between edges T+WORDS and T+WORDS+1. `sum` and `cout` are final during that cycle.
- `busy` falls after edge T+WORDS+1.
- The earliest next accepted `start` is at edge T+WORDS+2.
- Latency from start to done is `WORDS`+1 cycles. With `WORDS`=4, `done` is high in the 5th cycle after acceptance.
- The adder path is purely combinational within one cycle. No multicycle paths.

## Configuration
- Macro: `CLA_SEQ_SUB_EN`.
- When defined:
  - adds port `sub  input  1`, latched on the accepted `start`;
  - when the latched `sub`=1, every B slice is inverted before the adder and the initial carry is forced to 1 (`cin` is ignored), so `sum` = A − B mod 2^W;
  - `cout`=1 means no borrow (A ≥ B unsigned).
- When undefined: the `sub` port is absent and the block adds only.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `busy`=0, `done`=0, `sum`=0, `cout`=0; `start` is ignored while in reset.
- Slice carry: WORDS=4, a=0x0000_0000_0000_FFFF, b=0x1, cin=0 → sum=0x0000_0000_0001_0000, cout=0, `done` high exactly in cycle T+5 only.
- Full ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0, cout=1. Also a=1060, b=11000, cin=0 → sum=12060, cout=0.
- Busy lockout: accept start (a=12500, b=3100, cin=1), then pulse `start` with a=1, b=1 at T+2 and again during DONE → sum=15601, single `done`, second request never accepted, `busy` low at T+6.
- Mid-op reset: accept a=30143, b=2200, assert `rst_n`=0 between T+2 and T+3 → `sum`=0 and `busy`=0 immediately, no `done` after release. A fresh start (a=1140, b=21000, cin=1) then yields 22141.
- `CLA_SEQ_SUB_EN`: sub=1, a=5, b=7 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. Then sub=1, a=7, b=5 → sum=2, cout=1.

Source files
------------

// File: rtl/cla_multiword_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : cla_multiword_sequencer (+ cla16_adder)                     |
// | Brief    : Multi-precision adder that walks one shared 16-bit          |
// |            carry-lookahead adder over WORDS slices, LSB slice first,   |
// |            carrying between slices through a register.                 |
// | Options  : CLA_SEQ_SUB_EN adds a 'sub' port for A - B mod 2^W.         |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+

// 16-bit adder: four 4-bit lookahead groups plus a group-level lookahead.
module cla16_adder (
    output logic [15:0] s,
    output logic        cout,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin
);
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [3:0]  w_gg;
    logic [3:0]  w_pg;
    logic [4:0]  w_gc;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Group carries resolved in two levels rather than rippling group to group.
    assign w_gc[0] = cin;
    assign w_gc[1] = w_gg[0] | (w_pg[0] & w_gc[0]);
    assign w_gc[2] = w_gg[1] | (w_pg[1] & w_gg[0]) | (w_pg[1] & w_pg[0] & w_gc[0]);
    assign w_gc[3] = w_gg[2] | (w_pg[2] & w_gg[1]) | (w_pg[2] & w_pg[1] & w_gg[0])
                   | (w_pg[2] & w_pg[1] & w_pg[0] & w_gc[0]);
    assign w_gc[4] = w_gg[3] | (w_pg[3] & w_gg[2]) | (w_pg[3] & w_pg[2] & w_gg[1])
                   | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0])
                   | (w_pg[3] & w_pg[2] & w_pg[1] & w_pg[0] & w_gc[0]);

    for (genvar j = 0; j < 4; j++) begin : g_grp
        logic [3:0] w_gl;
        logic [3:0] w_pl;
        assign w_gl = w_g[4*j +: 4];
        assign w_pl = w_p[4*j +: 4];
        assign w_gg[j] = w_gl[3] | (w_pl[3] & w_gl[2]) | (w_pl[3] & w_pl[2] & w_gl[1])
                       | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0]);
        assign w_pg[j] = &w_pl;
        assign w_c[4*j]     = w_gc[j];
        assign w_c[4*j + 1] = w_gl[0] | (w_pl[0] & w_gc[j]);
        assign w_c[4*j + 2] = w_gl[1] | (w_pl[1] & w_gl[0]) | (w_pl[1] & w_pl[0] & w_gc[j]);
        assign w_c[4*j + 3] = w_gl[2] | (w_pl[2] & w_gl[1]) | (w_pl[2] & w_pl[1] & w_gl[0])
                            | (w_pl[2] & w_pl[1] & w_pl[0] & w_gc[j]);
    end

    assign s    = w_p ^ w_c;
    assign cout = w_gc[4];
endmodule

module cla_multiword_sequencer #(
    parameter int WORDS = 4
) (
`ifdef CLA_SEQ_SUB_EN
    input  logic                sub,
`endif
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [16*WORDS-1:0] a_in,
    input  logic [16*WORDS-1:0] b_in,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] sum,
    output logic                cout
);
    localparam int         W        = 16 * WORDS;
    localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   sum_q, sum_d;
    logic [2:0]     idx_q, idx_d;
    logic           carry_q, carry_d;
    logic           cout_q, cout_d;

    logic [15:0]    w_s;
    logic           w_cout;
    logic [W-1:0]   w_b_eff;
    logic           w_cin_eff;

    // Subtraction is folded into the latch: B is stored inverted and the
    // initial carry forced to 1, so the RUN datapath never changes.
`ifdef CLA_SEQ_SUB_EN
    assign w_b_eff   = sub ? ~b_in : b_in;
    assign w_cin_eff = sub ? 1'b1 : cin;
`else
    assign w_b_eff   = b_in;
    assign w_cin_eff = cin;
`endif

    cla16_adder u_adder (
        .s    (w_s),
        .cout (w_cout),
        .a    (a_q[16*idx_q +: 16]),
        .b    (b_q[16*idx_q +: 16]),
        .cin  (carry_q)
    );

    // State and datapath registers; async reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state: accept in IDLE, one slice per RUN cycle, single DONE cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a_in;
                    b_d     = w_b_eff;
                    carry_d = w_cin_eff;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end
            end
            RUN: begin
                sum_d[16*idx_q +: 16] = w_s;
                carry_d = w_cout;
                idx_d   = idx_q + 3'd1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = w_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule
`default_nettype wire

// File: tb/tb_cla_multiword_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_cla_multiword_sequencer                                  |
// | Brief    : Directed self-checking bench for cla_multiword_sequencer    |
// |            (WORDS = 4); sub vectors enabled with CLA_SEQ_SUB_EN.       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_cla_multiword_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_vec = 0;
    int n_err = 0;

    cla_multiword_sequencer #(.WORDS(WORDS)) dut (
`ifdef CLA_SEQ_SUB_EN
        .sub   (sub),
`endif
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; sampling happens 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, then find the cycle (edges after T) of done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic s, output int k_done);
        a_in  = a;
        b_in  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        a_in  = {$urandom, $urandom};
        b_in  = {$urandom, $urandom};
        cin   = 1'b1;
        sub   = 1'b0;
        k_done = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (done) begin
                k_done = k;
                break;
            end
        end
    endtask

    task automatic add_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic s,
                           input logic [W-1:0] exp_sum, input logic exp_cout);
        int k;
        run_op(a, b, c, s, k);
        chk({tag, "_done_cycle"}, W'(k), W'(WORDS));
        chk({tag, "_sum"}, sum, exp_sum);
        chk({tag, "_cout"}, W'(cout), W'(exp_cout));
        tick();
        chk({tag, "_done_pulse"}, W'(done), '0);
        chk({tag, "_busy_off"}, W'(busy), '0);
    endtask

    initial begin
        int k;
        int n_done;

        // Reset with live, random inputs and start asserted.
        rst_n = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in = {$urandom, $urandom};
            b_in = {$urandom, $urandom};
            cin  = 1'($urandom);
            tick();
        end
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_sum", sum, '0);
        chk("rst_cout", W'(cout), '0);
        start = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        chk("rst_start_ignored", W'(busy), '0);

        add_vec("slice_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
                64'h0000_0000_0001_0000, 1'b0);
        add_vec("full_ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1);
        add_vec("small_add", 64'd1060, 64'd11000, 1'b0, 1'b0, 64'd12060, 1'b0);
        add_vec("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
                64'h2222_2222_2222_2211, 1'b0);
        add_vec("top_carry", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, 1'b0,
                64'h0000_0000_0000_0001, 1'b1);

        // Busy lockout: extra requests at T+2 and during DONE are dropped.
        tick();
        a_in = 64'd12500; b_in = 64'd3100; cin = 1'b1; start = 1'b1;
        tick();                       // edge T
        start = 1'b0;
        chk("lock_busy_T", W'(busy), 64'd1);
        tick();                       // edge T+1
        a_in = 64'd1; b_in = 64'd1; cin = 1'b0; start = 1'b1;
        tick();                       // edge T+2, ignored
        start = 1'b0;
        tick();                       // edge T+3
        tick();                       // edge T+4
        chk("lock_done", W'(done), 64'd1);
        start = 1'b1;                 // sampled at T+5 while in DONE
        tick();                       // edge T+5
        start = 1'b0;
        chk("lock_sum", sum, 64'd15601);
        chk("lock_busy_T5", W'(busy), '0);
        tick();                       // edge T+6
        chk("lock_busy_T6", W'(busy), '0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) n_done++;
        end
        chk("lock_no_second_op", W'(n_done), '0);
        chk("lock_sum_held", sum, 64'd15601);

        // Mid-operation reset between T+2 and T+3.
        a_in = 64'd30143; b_in = 64'd2200; cin = 1'b0; start = 1'b1;
        tick();                       // edge T
        start = 1'b0;
        tick();                       // edge T+1
        tick();                       // edge T+2
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sum", sum, '0);
        chk("midrst_busy", W'(busy), '0);
        tick();
        #2 rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) n_done++;
        end
        chk("midrst_no_done", W'(n_done), '0);
        add_vec("after_rst", 64'd1140, 64'd21000, 1'b1, 1'b0, 64'd22141, 1'b0);

`ifdef CLA_SEQ_SUB_EN
        add_vec("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        add_vec("sub_pos", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time guard so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded, got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
